// File: rtl/flexbus_pkg.sv
// Shared FlexBus slave definitions: FSM state encoding, wait counter width,
// the value returned for out-of-range reads and the byte-lane merge helper.
package flexbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_XFER = 2'd3
  } fb_state_e;

  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] RANGE_RD_VAL = 32'h0000_0000;

  // Lanes whose active-low enable is asserted take the new byte.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be_n);
    logic [31:0] res;
    res = old_v;
    for (int j = 0; j < 4; j++) begin
      if (!be_n[j]) begin
        res[8*j +: 8] = new_v[8*j +: 8];
      end else begin
        res[8*j +: 8] = old_v[8*j +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/flexbus_slave_fsm.sv
// FlexBus slave handshake: address/wait/transfer sequencing, wait-state
// counter and registered transfer acknowledge. Runs on the falling clock edge.
module flexbus_slave_fsm
  import flexbus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ale,
  input  logic      hit,
  input  logic      cs_n,
  output fb_state_e state,
  output logic      ta_n,
  output logic      addr_go,
  output logic      xfer_done
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES == 0) ? {CNT_W{1'b0}} : CNT_W'(WAIT_STATES - 1);

  fb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ta_n_q, ta_n_d;

  // Next-state logic; an address phase overrides whatever is in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ale) begin
      state_d = hit ? ST_ADDR : ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ADDR: begin
          if (!cs_n) begin
            if (WAIT_STATES == 0) begin
              state_d = ST_XFER;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = CNT_INIT;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_WAIT: begin
          if (cs_n) begin
            state_d = ST_IDLE;
          end else if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = ST_XFER;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_XFER: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    ta_n_d = (state_d != ST_XFER);
  end

  // State, counter and acknowledge registers.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      ta_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ta_n_q  <= ta_n_d;
    end
  end

  assign state     = state_q;
  assign ta_n      = ta_n_q;
  assign addr_go   = (state_q == ST_ADDR) && !ale && !cs_n;
  assign xfer_done = (state_q == ST_XFER) && !ale && !cs_n;

endmodule

// File: rtl/flexbus_regfile.sv
// FlexBus-attached register file: N_REGS 32-bit registers with byte-lane
// writes, read-only status mirrors, write strobes and an out-of-range counter.
module flexbus_regfile
  import flexbus_pkg::*;
#(
  parameter int unsigned       N_REGS      = 8,
  parameter logic [31:0]       BASE_MASK   = 32'hF000_0000,
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [N_REGS-1:0] RO_MASK     = {N_REGS{1'b0}}
) (
  input  logic                FB_CLK,
  input  logic                RST,
  input  logic [31:0]         FB_BASE,
  input  logic                FB_ALE,
  input  logic                FB_CS_n,
  input  logic                FB_RW,
  input  logic [3:0]          FB_BE_n,
  inout  wire  [31:0]         FB_AD,
  output logic                FB_TA_n,
  output logic [N_REGS*32-1:0] REG_Q,
  input  logic [N_REGS*32-1:0] STAT_D,
  output logic [N_REGS-1:0]   WR_STB,
  output logic [15:0]         ERR_CNT
);

  localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * N_REGS);

  fb_state_e   state_s;
  logic        hit_s, range_s, addr_go_s, xfer_done_s, ad_oe_s;
  logic [31:0] rd_sel_s;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              range_q, range_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [31:0]       regs_q [N_REGS];
  logic [31:0]       regs_d [N_REGS];
  logic [N_REGS-1:0] wr_stb_q, wr_stb_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  assign hit_s   = FB_ALE && ((FB_AD & BASE_MASK) == (FB_BASE & BASE_MASK));
  assign range_s = ((FB_AD & ~BASE_MASK) >= SPAN) || (FB_AD[1:0] != 2'b00);

  flexbus_slave_fsm #(
    .WAIT_STATES (WAIT_STATES)
  ) u_fsm (
    .clk       (FB_CLK),
    .rst       (RST),
    .ale       (FB_ALE),
    .hit       (hit_s),
    .cs_n      (FB_CS_n),
    .state     (state_s),
    .ta_n      (FB_TA_n),
    .addr_go   (addr_go_s),
    .xfer_done (xfer_done_s)
  );

  // Read source: status input for read-only slots, zero when out of range.
  always_comb begin
    if (range_q) begin
      rd_sel_s = RANGE_RD_VAL;
    end else if (RO_MASK[idx_q]) begin
      rd_sel_s = STAT_D[{idx_q, 5'd0} +: 32];
    end else begin
      rd_sel_s = regs_q[idx_q];
    end
  end

  // Register array, read-data, strobe and error-counter next state.
  always_comb begin
    idx_d     = idx_q;
    range_d   = range_q;
    rd_data_d = rd_data_q;
    wr_stb_d  = {N_REGS{1'b0}};
    err_cnt_d = err_cnt_q;
    regs_d    = regs_q;
    for (int i = 0; i < N_REGS; i++) begin
      if (RO_MASK[i]) begin
        regs_d[i] = STAT_D[32*i +: 32];
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    if (hit_s) begin
      idx_d   = FB_AD[IDX_W+1:2];
      range_d = range_s;
    end else begin
      idx_d   = idx_q;
      range_d = range_q;
    end
    if (addr_go_s && FB_RW) begin
      rd_data_d = rd_sel_s;
    end else begin
      rd_data_d = rd_data_q;
    end
    if (xfer_done_s) begin
      if (range_q) begin
        err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
      end else if (!FB_RW && !RO_MASK[idx_q]) begin
        regs_d[idx_q]   = be_merge(regs_q[idx_q], FB_AD, FB_BE_n);
        wr_stb_d[idx_q] = 1'b1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(negedge FB_CLK) begin
    if (RST) begin
      idx_q     <= {IDX_W{1'b0}};
      range_q   <= 1'b0;
      rd_data_q <= 32'h0000_0000;
      regs_q    <= '{default: 32'h0000_0000};
      wr_stb_q  <= {N_REGS{1'b0}};
      err_cnt_q <= 16'h0000;
    end else begin
      idx_q     <= idx_d;
      range_q   <= range_d;
      rd_data_q <= rd_data_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_reg_q
    assign REG_Q[32*g +: 32] = regs_q[g];
  end

  assign ad_oe_s = ((state_s == ST_WAIT) || (state_s == ST_XFER)) && FB_RW && !FB_CS_n;
  assign FB_AD   = ad_oe_s ? rd_data_q : 32'hzzzz_zzzz;
  assign WR_STB  = wr_stb_q;
  assign ERR_CNT = err_cnt_q;

endmodule
